fp_mac_issue_ctrl: RTL and testbench
====================================

Name: fp_mac_issue_ctrl

Overview:
- Initiator-side controller that drives a pipelined FP MAC unit.
- The unit has fixed latency and cannot stall; it asserts valid for one cycle and holds ready at 1.
- This block accepts core requests on a req/gnt handshake and issues them to the unit with En. It collects results into a response FIFO that the core drains with valid/ready.
- A credit counter guarantees FIFO space for every in-flight operation, so the unit is never back-pressured. A latency checker flags protocol violations from the unit.

Parameters:
- TAG_WIDTH, 4, width of the request tag; passed through the unit unmodified.
- RND_WIDTH, NDSFLAGS_MAC, width of the rounding-mode field.
- STAT_WIDTH, NUSFLAGS_MAC, width of the status flags.
- C_MAC_PIPE_REGS, 0, latency of the attached unit in cycles (0 = combinational).
- RESP_DEPTH, 4, response FIFO entries; must be >= 1 and equals the maximum outstanding operations (in flight plus buffered).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- Req_i  in  1  core request
- Gnt_o  out  1  request accepted this cycle
- OpA_i/OpB_i/OpC_i  in  FP_WIDTH  operands
- Op_i  in  2  [1] negates the product, [0] negates the addend
- Tag_i  in  TAG_WIDTH  request tag
- Rnd_i  in  RND_WIDTH  rounding mode
- RValid_o  out  1  result available
- RReady_i  in  1  core consumes result
- RRes_o  out  FP_WIDTH  result
- RStatus_o  out  STAT_WIDTH  status flags
- RTag_o  out  TAG_WIDTH  tag of the result
- UEn_o  out  1  unit enable (issue)
- UOpA_o/UOpB_o/UOpC_o  out  FP_WIDTH  operands to the unit
- UOp_o  out  2  op to the unit
- UTag_o  out  TAG_WIDTH  tag to the unit
- URnd_o  out  RND_WIDTH  rounding mode to the unit
- URes_i  in  FP_WIDTH  unit result
- UStatus_i  in  STAT_WIDTH  unit status
- UTag_i  in  TAG_WIDTH  unit returned tag
- UValid_i  in  1  unit result valid
- UReady_i  in  1  unit ready
- UAck_o  out  1  acknowledge to the unit
- Err_o  out  1  sticky protocol error

Behaviour:
- Clock and reset: single clock clk_i; rst_ni is asynchronous, active-low.
- Reset values: Gnt_o=0, UEn_o=0, RValid_o=0, Err_o=0, credit counter=0, FIFO empty, latency shift register cleared. Data outputs are 0 while the FIFO is empty.
- Issue (combinational): Gnt_o = Req_i & UReady_i & (credits < RESP_DEPTH). UEn_o = Gnt_o.
- Operand forwarding: UOp*/UTag/URnd forward the core inputs unchanged. Sign handling is done by the unit.
- Credit counter: $clog2(RESP_DEPTH+1) bits.
  - +1 on issue.
  - −1 on FIFO pop (RValid_o & RReady_i).
  - Both in the same cycle: counter unchanged.
  - Counter never exceeds RESP_DEPTH and never goes below 0.
- FIFO write: on UValid_i, {URes_i, UStatus_i, UTag_i} is written to the FIFO. UAck_o = UValid_i.
- FIFO organisation: registered, not fall-through. RValid_o = !empty.
- Minimum latency: issue to RValid_o is C_MAC_PIPE_REGS+1 cycles.
- Simultaneous events: push and pop in the same cycle are legal at any occupancy, including full. The FIFO pointers wrap modulo RESP_DEPTH.
- FIFO ordering: results leave in issue order, since the unit is in-order.
- Latency checker:
  - An expect shift register of length C_MAC_PIPE_REGS is loaded with UEn_o.
  - For C_MAC_PIPE_REGS=0, the expected bit is UEn_o itself.
  - If UValid_i differs from the expected bit, Err_o is set.
  - A push while the FIFO is full and no pop occurs is dropped and sets Err_o.
  - Err_o is sticky until reset.
- Reset mid-operation: all in-flight operations are discarded. Results arriving after reset from a non-reset unit set Err_o; the unit shares rst_ni, so this is not expected.
- Req_i held without Gnt_o: the request is not issued and no state changes. The core must hold its inputs stable until Gnt_o.

Decomposition:
- apu_cluster_package:
  - typedef fp_mac_resp_t, a struct of {res FP_WIDTH, status STAT_WIDTH, tag TAG_WIDTH}; the tag width is fixed via a package constant MAC_TAG_WIDTH.
  - Constant FP_MAC_RESP_DEPTH = 4.
  - Existing constants FP_WIDTH, NDSFLAGS_MAC, NUSFLAGS_MAC.
- Sub-module fp_resp_fifo, parameterised by DEPTH and the data type:
  - ports: push, pop, data in, data out, full, empty.
  - behaviour: circular buffer with read/write pointers and an occupancy count.
- The credit counter and latency checker stay in the top module.

Test Plan:
- Single operation, RReady_i=1, C_MAC_PIPE_REGS=2:
  - stimulus: Req_i with OpA=0x40000000, OpB=0x40400000, OpC=0x3F800000, Op=00, Tag=5.
  - response: Gnt_o in the same cycle; RValid_o 3 cycles later with RRes_o=0x40E00000 (7.0) and RTag_o=5.
- Op=01 on the same operands -> RRes_o=0x40A00000 (5.0). Op=10 -> 0xC0A00000 (−5.0).
- Back-pressure:
  - stimulus: RReady_i=0, Req_i held high.
  - response: exactly 4 grants, then Gnt_o=0.
  - stimulus: RReady_i pulsed for 1 cycle.
  - response: exactly one further grant on the following cycle; results pop in tag order 0,1,2,3.
- Simultaneous push/pop with the FIFO full and RReady_i=1 every cycle -> throughput of 1 op/cycle sustained over 20 ops, no Err_o.
- Protocol errors:
  - UValid_i injected one cycle late -> Err_o=1 next cycle and stays high.
  - Spurious UValid_i with no issue -> Err_o=1.
- Reset mid-operation:
  - stimulus: rst_ni asserted with 3 ops in flight.
  - response: RValid_o=0, credits=0, Err_o=0 after release; a new op then completes normally.

Source files
------------

// File: rtl/fp_mac_issue_ctrl_pkg.sv
// Shared constants and the response record for the FP MAC issue controller.
package fp_mac_issue_ctrl_pkg;

    localparam int FP_WIDTH          = 32;
    localparam int NDSFLAGS_MAC      = 3;
    localparam int NUSFLAGS_MAC      = 5;
    localparam int MAC_TAG_WIDTH     = 4;
    localparam int FP_MAC_RESP_DEPTH = 4;

    // One result as returned by the MAC unit and held in the response FIFO.
    typedef struct packed {
        logic [FP_WIDTH-1:0]      res;
        logic [NUSFLAGS_MAC-1:0]  status;
        logic [MAC_TAG_WIDTH-1:0] tag;
    } fp_mac_resp_t;

    // Width of a counter that must hold values 0..depth inclusive.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fp_mac_issue_ctrl_if.sv
// Core-side request/response bundle: req/gnt issue handshake and valid/ready result drain.
interface fp_mac_issue_ctrl_if
    import fp_mac_issue_ctrl_pkg::*;
#(
    parameter int TAG_WIDTH  = MAC_TAG_WIDTH,
    parameter int RND_WIDTH  = NDSFLAGS_MAC,
    parameter int STAT_WIDTH = NUSFLAGS_MAC
) ();

    logic                  Req_i;
    logic                  Gnt_o;
    logic [FP_WIDTH-1:0]   OpA_i;
    logic [FP_WIDTH-1:0]   OpB_i;
    logic [FP_WIDTH-1:0]   OpC_i;
    logic [1:0]            Op_i;
    logic [TAG_WIDTH-1:0]  Tag_i;
    logic [RND_WIDTH-1:0]  Rnd_i;
    logic                  RValid_o;
    logic                  RReady_i;
    logic [FP_WIDTH-1:0]   RRes_o;
    logic [STAT_WIDTH-1:0] RStatus_o;
    logic [TAG_WIDTH-1:0]  RTag_o;

    // The core drives requests and consumes results.
    modport master (
        output Req_i, OpA_i, OpB_i, OpC_i, Op_i, Tag_i, Rnd_i, RReady_i,
        input  Gnt_o, RValid_o, RRes_o, RStatus_o, RTag_o
    );

    // The controller accepts requests and presents results.
    modport slave (
        input  Req_i, OpA_i, OpB_i, OpC_i, Op_i, Tag_i, Rnd_i, RReady_i,
        output Gnt_o, RValid_o, RRes_o, RStatus_o, RTag_o
    );

endinterface

// File: rtl/fp_mac_issue_ctrl_resp_fifo.sv
// Registered circular-buffer response FIFO; output reads as zero while empty.
module fp_resp_fifo
    import fp_mac_issue_ctrl_pkg::*;
#(
    parameter int  DEPTH = FP_MAC_RESP_DEPTH,
    parameter type T     = fp_mac_resp_t
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic i_push,
    input  logic i_pop,
    input  T     i_data,
    output T     o_data,
    output logic o_full,
    output logic o_empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = cnt_width(DEPTH);

    T                 r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    // Pointers wrap at DEPTH, which need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign w_do_pop  = i_pop & ~o_empty;
    // A pop frees the head slot this edge, so a push into a full FIFO is fine then.
    assign w_do_push = i_push & (~o_full | w_do_pop);
    assign o_data    = o_empty ? '0 : r_mem[r_rd_ptr];

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (w_do_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage is data only and needs no reset.
    always_ff @(posedge clk_i) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/fp_mac_issue_ctrl.sv
// Issue controller for a fixed-latency, non-stalling FP MAC unit: credit-based
// issue, in-order response buffering and a latency/protocol checker.
module fp_mac_issue_ctrl
    import fp_mac_issue_ctrl_pkg::*;
#(
    parameter int TAG_WIDTH       = MAC_TAG_WIDTH,
    parameter int RND_WIDTH       = NDSFLAGS_MAC,
    parameter int STAT_WIDTH      = NUSFLAGS_MAC,
    parameter int C_MAC_PIPE_REGS = 0,
    parameter int RESP_DEPTH      = FP_MAC_RESP_DEPTH
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    fp_mac_issue_ctrl_if.slave    core,
    output logic                  UEn_o,
    output logic [FP_WIDTH-1:0]   UOpA_o,
    output logic [FP_WIDTH-1:0]   UOpB_o,
    output logic [FP_WIDTH-1:0]   UOpC_o,
    output logic [1:0]            UOp_o,
    output logic [TAG_WIDTH-1:0]  UTag_o,
    output logic [RND_WIDTH-1:0]  URnd_o,
    input  logic [FP_WIDTH-1:0]   URes_i,
    input  logic [STAT_WIDTH-1:0] UStatus_i,
    input  logic [TAG_WIDTH-1:0]  UTag_i,
    input  logic                  UValid_i,
    input  logic                  UReady_i,
    output logic                  UAck_o,
    output logic                  Err_o
);

    localparam int CNT_W = cnt_width(RESP_DEPTH);

    logic [CNT_W-1:0] r_credits;
    logic             r_err;
    logic             w_gnt;
    logic             w_pop;
    logic             w_full;
    logic             w_empty;
    logic             w_exp_valid;
    fp_mac_resp_t     w_wr_data;
    fp_mac_resp_t     w_rd_data;

    // Credits count in-flight plus buffered results, so a grant always has a FIFO slot.
    // Grants are held off while reset is asserted so no request is accepted and lost.
    assign w_gnt      = rst_ni & core.Req_i & UReady_i & (r_credits < CNT_W'(RESP_DEPTH));
    assign w_pop      = ~w_empty & core.RReady_i;
    assign core.Gnt_o = w_gnt;
    assign UEn_o      = w_gnt;
    assign UAck_o     = UValid_i;

    assign UOpA_o = core.OpA_i;
    assign UOpB_o = core.OpB_i;
    assign UOpC_o = core.OpC_i;
    assign UOp_o  = core.Op_i;
    assign UTag_o = core.Tag_i;
    assign URnd_o = core.Rnd_i;

    assign w_wr_data      = '{res: URes_i, status: UStatus_i, tag: UTag_i};
    assign core.RValid_o  = ~w_empty;
    assign core.RRes_o    = w_rd_data.res;
    assign core.RStatus_o = w_rd_data.status;
    assign core.RTag_o    = w_rd_data.tag;
    assign Err_o          = r_err;

    fp_resp_fifo #(
        .DEPTH (RESP_DEPTH),
        .T     (fp_mac_resp_t)
    ) u_resp_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .i_push  (UValid_i),
        .i_pop   (w_pop),
        .i_data  (w_wr_data),
        .o_data  (w_rd_data),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Expected-valid pipeline mirrors the unit latency; a combinational unit answers in the issue cycle.
    if (C_MAC_PIPE_REGS == 0) begin : g_exp_comb
        assign w_exp_valid = w_gnt;
    end else begin : g_exp_pipe
        logic [C_MAC_PIPE_REGS-1:0] r_exp;
        // Shift issue strobes toward the cycle their result is due.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) r_exp <= '0;
            else         r_exp <= (r_exp << 1) | C_MAC_PIPE_REGS'(w_gnt);
        end
        assign w_exp_valid = r_exp[C_MAC_PIPE_REGS-1];
    end

    // Credit counter: issue adds, pop removes, both together cancel.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_credits <= '0;
        end else begin
            case ({w_gnt, w_pop})
                2'b10:   r_credits <= r_credits + CNT_W'(1);
                2'b01:   r_credits <= (r_credits != '0) ? r_credits - CNT_W'(1) : r_credits;
                default: r_credits <= r_credits;
            endcase
        end
    end

    // Sticky error on an early/late/spurious unit valid or a push dropped by a full FIFO.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_err <= 1'b0;
        else if ((UValid_i != w_exp_valid) || (UValid_i & w_full & ~w_pop)) r_err <= 1'b1;
    end

endmodule

// File: tb/tb_fp_mac_issue_ctrl.sv
// Bench for fp_mac_issue_ctrl with a 2-stage MAC unit stub and a queue-based reference model.
module tb_fp_mac_issue_ctrl;
    import fp_mac_issue_ctrl_pkg::*;

    localparam int LAT   = 2;
    localparam int DEPTH = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fp_mac_issue_ctrl_if cif ();

    logic        UEn_o, UValid_i, UReady_i, UAck_o, Err_o;
    logic [31:0] UOpA_o, UOpB_o, UOpC_o, URes_i;
    logic [1:0]  UOp_o;
    logic [3:0]  UTag_o, UTag_i;
    logic [2:0]  URnd_o;
    logic [4:0]  UStatus_i;

    fp_mac_issue_ctrl #(
        .TAG_WIDTH       (4),
        .RND_WIDTH       (3),
        .STAT_WIDTH      (5),
        .C_MAC_PIPE_REGS (LAT),
        .RESP_DEPTH      (DEPTH)
    ) dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .core      (cif),
        .UEn_o     (UEn_o),
        .UOpA_o    (UOpA_o),
        .UOpB_o    (UOpB_o),
        .UOpC_o    (UOpC_o),
        .UOp_o     (UOp_o),
        .UTag_o    (UTag_o),
        .URnd_o    (URnd_o),
        .URes_i    (URes_i),
        .UStatus_i (UStatus_i),
        .UTag_i    (UTag_i),
        .UValid_i  (UValid_i),
        .UReady_i  (UReady_i),
        .UAck_o    (UAck_o),
        .Err_o     (Err_o)
    );

    // ---------------- floating-point helpers (exact for the small operands used) ----------------
    function automatic real f2r(input logic [31:0] b);
        real m;
        int  e;
        if (b[30:0] == 31'd0) return 0.0;
        e = int'(b[30:23]) - 127;
        m = (1.0 + real'(b[22:0]) / 8388608.0) * (2.0 ** e);
        return b[31] ? -m : m;
    endfunction

    function automatic logic [31:0] r2f(input real r);
        logic [63:0] d;
        d = $realtobits(r);
        if (d[62:0] == 63'd0) return {d[63], 31'd0};
        return {d[63], 8'(int'(d[62:52]) - 896), d[51:29]};
    endfunction

    function automatic logic [31:0] mac(input logic [31:0] a, b, c, input logic [1:0] op);
        real p, q;
        p = f2r(a) * f2r(b);
        q = f2r(c);
        if (op[1]) p = -p;
        if (op[0]) q = -q;
        return r2f(p + q);
    endfunction

    function automatic logic [4:0] stat_of(input logic [3:0] t);
        return {1'b0, t} ^ 5'b10101;
    endfunction

    // ---------------- MAC unit stub: fixed latency, never stalls ----------------
    logic [LAT-1:0] sv;
    logic [31:0]    sres [LAT];
    logic [3:0]     stag [LAT];
    logic           suppress = 1'b0;
    logic           inject   = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sv <= '0;
        end else begin
            sv      <= {sv[0], UEn_o};
            sres[0] <= mac(UOpA_o, UOpB_o, UOpC_o, UOp_o);
            sres[1] <= sres[0];
            stag[0] <= UTag_o;
            stag[1] <= stag[0];
        end
    end

    assign UValid_i  = (sv[LAT-1] & ~suppress) | inject;
    assign URes_i    = sres[LAT-1];
    assign UTag_i    = stag[LAT-1];
    assign UStatus_i = stat_of(stag[LAT-1]);
    assign UReady_i  = 1'b1;

    // ---------------- reference model: outstanding ops in issue order ----------------
    typedef struct {
        logic [31:0] res;
        logic [3:0]  tag;
        logic [4:0]  st;
        int          t;
    } ent_t;

    ent_t       q[$];
    logic [3:0] popped[$];
    int         total = 0;
    int         bad   = 0;
    int         cycle = 0;
    int         ngnt  = 0;
    bit         chk   = 1'b1;
    bit         last_gnt;
    logic [31:0] fpv [4] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h3F000000};

    task automatic chk1(input string nm, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", nm, obs, exp);
        end
    endtask

    // One clock: check outputs at negedge against the model, advance the model at posedge.
    task automatic cyc();
        bit eg, ev;
        @(negedge clk);
        eg = cif.Req_i && (q.size() < DEPTH);
        ev = (q.size() > 0) && (q[0].t <= cycle);
        if (chk) begin
            chk1("gnt", cif.Gnt_o, eg);
            chk1("uen", UEn_o, eg);
            chk1("rvalid", cif.RValid_o, ev);
            if (ev) begin
                chk1("rres", cif.RRes_o, q[0].res);
                chk1("rtag", cif.RTag_o, q[0].tag);
                chk1("rstatus", cif.RStatus_o, q[0].st);
            end else begin
                chk1("rres_idle", cif.RRes_o, 32'd0);
            end
            chk1("err", Err_o, 1'b0);
            chk1("fwd_a", UOpA_o, cif.OpA_i);
            chk1("fwd_misc", {UOpB_o[7:0], UOpC_o[7:0], UOp_o, UTag_o, URnd_o},
                 {cif.OpB_i[7:0], cif.OpC_i[7:0], cif.Op_i, cif.Tag_i, cif.Rnd_i});
        end
        @(posedge clk);
        last_gnt = eg;
        if (eg) ngnt++;
        if (chk) begin
            if (ev && cif.RReady_i) begin
                popped.push_back(q[0].tag);
                void'(q.pop_front());
            end
            if (eg) q.push_back('{mac(cif.OpA_i, cif.OpB_i, cif.OpC_i, cif.Op_i),
                                  cif.Tag_i, stat_of(cif.Tag_i), cycle + LAT + 1});
        end
        cycle++;
        #1;
    endtask

    task automatic single(input logic [1:0] op, input logic [31:0] exp_res, input string nm);
        cif.Req_i = 1'b1; cif.OpA_i = 32'h40000000; cif.OpB_i = 32'h40400000;
        cif.OpC_i = 32'h3F800000; cif.Op_i = op; cif.Tag_i = 4'd5; cif.RReady_i = 1'b1;
        #1;
        chk1({nm, "_gnt_same_cycle"}, cif.Gnt_o, 1'b1);
        cyc();
        cif.Req_i = 1'b0;
        cyc();
        cyc();
        chk1({nm, "_valid"}, cif.RValid_o, 1'b1);
        chk1({nm, "_res"}, cif.RRes_o, exp_res);
        chk1({nm, "_tag"}, cif.RTag_o, 32'd5);
        cyc();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk1("rst_rvalid", cif.RValid_o, 1'b0);
        chk1("rst_err", Err_o, 1'b0);
        chk1("rst_rres", cif.RRes_o, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        q.delete();
        cycle = 0;
    endtask

    initial begin
        cif.Req_i = 1'b1; cif.OpA_i = '0; cif.OpB_i = '0; cif.OpC_i = '0;
        cif.Op_i = '0; cif.Tag_i = '0; cif.Rnd_i = 3'd2; cif.RReady_i = 1'b1;

        // Reset state, with a request pending that must not be granted.
        #12;
        chk1("reset_gnt", cif.Gnt_o, 1'b0);
        chk1("reset_uen", UEn_o, 1'b0);
        cif.Req_i = 1'b0;
        do_reset();
        repeat (2) cyc();

        // Directed single operations: latency and op-bit semantics.
        single(2'b00, 32'h40E00000, "op00");
        single(2'b01, 32'h40A00000, "op01");
        single(2'b10, 32'hC0A00000, "op10");

        // Back-pressure: four grants fill the credits, one pop releases one more.
        cif.RReady_i = 1'b0; cif.Req_i = 1'b1; cif.Tag_i = 4'd0; cif.Op_i = 2'b00;
        ngnt = 0;
        repeat (8) begin cyc(); if (last_gnt) cif.Tag_i++; end
        chk1("bp_grants", ngnt, 32'd4);
        chk1("bp_gnt_low", cif.Gnt_o, 1'b0);
        popped.delete();
        cif.RReady_i = 1'b1;
        cyc();
        cif.RReady_i = 1'b0;
        ngnt = 0;
        repeat (4) begin cyc(); if (last_gnt) cif.Tag_i++; end
        chk1("bp_one_more", ngnt, 32'd1);
        cif.Req_i = 1'b0; cif.RReady_i = 1'b1;
        repeat (8) cyc();
        chk1("bp_pop_count", popped.size(), 32'd5);
        for (int i = 0; i < 4; i++)
            if (i < popped.size()) chk1($sformatf("bp_order%0d", i), popped[i], i);

        // Sustained throughput with continuous drain.
        cif.Req_i = 1'b1;
        repeat (4) begin cyc(); if (last_gnt) cif.Tag_i++; end
        ngnt = 0;
        repeat (20) begin cyc(); if (last_gnt) cif.Tag_i++; end
        chk1("tput", ngnt, 32'd20);
        cif.Req_i = 1'b0;
        repeat (6) cyc();

        // Randomised traffic; inputs stay stable while a request waits for a grant.
        repeat (300) begin
            if (!cif.Req_i || last_gnt) begin
                cif.Req_i = 1'($urandom_range(0, 1));
                cif.OpA_i = fpv[$urandom_range(0, 3)];
                cif.OpB_i = fpv[$urandom_range(0, 3)];
                cif.OpC_i = fpv[$urandom_range(0, 3)];
                cif.Op_i  = 2'($urandom_range(0, 3));
                cif.Tag_i = 4'($urandom_range(0, 15));
                cif.Rnd_i = 3'($urandom_range(0, 7));
            end
            cif.RReady_i = ($urandom_range(0, 9) < 7);
            cyc();
        end
        cif.Req_i = 1'b0; cif.RReady_i = 1'b1;
        repeat (10) cyc();

        // Reset with three operations in flight, then normal operation resumes.
        cif.Req_i = 1'b1;
        repeat (3) cyc();
        cif.Req_i = 1'b0;
        do_reset();
        repeat (4) cyc();
        single(2'b00, 32'h40E00000, "post_rst");
        cif.Req_i = 1'b1; cif.RReady_i = 1'b0;
        ngnt = 0;
        repeat (8) cyc();
        chk1("post_rst_credits", ngnt, 32'd4);
        cif.Req_i = 1'b0; cif.RReady_i = 1'b1;
        repeat (8) cyc();

        // Late unit valid: error raised and sticky.
        chk = 1'b0;
        cif.Req_i = 1'b1;
        cyc();
        cif.Req_i = 1'b0;
        cyc();
        suppress = 1'b1;
        cyc();
        suppress = 1'b0; inject = 1'b1;
        chk1("late_err", Err_o, 1'b1);
        cyc();
        inject = 1'b0;
        repeat (5) cyc();
        chk1("late_sticky", Err_o, 1'b1);
        do_reset();

        // Spurious unit valid with nothing issued.
        cyc();
        chk1("spur_pre", Err_o, 1'b0);
        inject = 1'b1;
        cyc();
        inject = 1'b0;
        chk1("spur_err", Err_o, 1'b1);
        repeat (3) cyc();
        chk1("spur_sticky", Err_o, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
